// File: rtl/bsg_upstream_pkg.sv
// bsg_upstream_pkg: shared FSM state type and sizing helpers for the upstream serializer
package bsg_upstream_pkg;
  typedef enum logic {IDLE, SEND} state_e;
  function automatic int beats_f(input int core_w, input int ch_num, input int ch_w);
    return core_w / (ch_num * ch_w);
  endfunction
  function automatic int credit_w_f(input int credit_max);
    return $clog2(credit_max + 1);
  endfunction
  function automatic int beat_w_f(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/bsg_upstream_credit_ctr.sv
// bsg_upstream_credit_ctr: saturating credit up/down counter with sticky overflow flag
module bsg_upstream_credit_ctr import bsg_upstream_pkg::*; #(
  parameter int CREDIT_MAX  = 16,
  parameter int CREDIT_INIT = CREDIT_MAX,
  localparam int CW = credit_w_f(CREDIT_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          err
);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CW'(CREDIT_INIT);
      err <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == CW'(CREDIT_MAX)) err <= 1'b1;
      else cnt <= cnt + CW'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/bsg_upstream_serializer.sv
// bsg_upstream_serializer: credit-gated core-word to multi-channel beat serializer.
// Define BSG_UPSTREAM_PARITY_EN to add per-channel even parity output io_parity_out.
module bsg_upstream_serializer import bsg_upstream_pkg::*; #(
  parameter int CORE_W      = 64,
  parameter int CH_NUM      = 2,
  parameter int CH_W        = 8,
  parameter int CREDIT_MAX  = 16,
  parameter int CREDIT_INIT = CREDIT_MAX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_valid_in,
  input  logic [CORE_W-1:0]             core_data_in,
  output logic                          core_ready_out,
  input  logic                          io_token,
  output logic                          io_valid_out,
  output logic [CH_NUM*CH_W-1:0]        io_data_out,
`ifdef BSG_UPSTREAM_PARITY_EN
  output logic [CH_NUM-1:0]             io_parity_out,
`endif
  output logic [$clog2(CREDIT_MAX+1)-1:0] credit_cnt_o,
  output logic                          credit_err_o
);
  localparam int BW    = CH_NUM * CH_W;
  localparam int BEATS = beats_f(CORE_W, CH_NUM, CH_W);
  localparam int QW    = beat_w_f(BEATS);
  if (CORE_W % BW != 0 || BEATS < 1) begin : g_bad_cfg
    $error("CORE_W must be a non-zero multiple of CH_NUM*CH_W");
  end
  state_e            state_q, state_d;
  logic [QW-1:0]     beat_q, beat_d;
  logic [CORE_W-1:0] word_q, word_d;
  logic              last, accept;
  assign last           = state_q == SEND && beat_q == QW'(BEATS - 1);
  assign core_ready_out = credit_cnt_o != '0 && (state_q == IDLE || last);
  assign accept         = core_valid_in & core_ready_out;
  // the holding register shifts down one beat per cycle, so the current beat is always its low slice
  always_comb begin
    state_d = accept ? SEND : last ? IDLE : state_q;
    beat_d  = (accept || last) ? '0 : state_q == SEND ? beat_q + QW'(1) : beat_q;
    word_d  = accept ? core_data_in : last ? '0 : state_q == SEND ? word_q >> BW : word_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
    end
  end
  assign io_valid_out = state_q == SEND;
  assign io_data_out  = io_valid_out ? word_q[BW-1:0] : '0;
`ifdef BSG_UPSTREAM_PARITY_EN
  for (genvar c = 0; c < CH_NUM; c++) begin : g_par
    assign io_parity_out[c] = ^io_data_out[c*CH_W +: CH_W];
  end
`endif
  bsg_upstream_credit_ctr #(
    .CREDIT_MAX (CREDIT_MAX),
    .CREDIT_INIT(CREDIT_INIT)
  ) u_credit (
    .clk(clk),
    .rst(rst),
    .dec(accept),
    .inc(io_token),
    .cnt(credit_cnt_o),
    .err(credit_err_o)
  );
endmodule

// File: tb/tb_bsg_upstream_serializer.sv
// tb_bsg_upstream_serializer: directed self-checking bench for the upstream serializer
module tb_bsg_upstream_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        v0, t0, rdy0, val0, err0;
  logic [63:0] d0;
  logic [15:0] dat0;
  logic [4:0]  cnt0;
  logic        v1, t1, rdy1, val1, err1;
  logic [63:0] d1;
  logic [15:0] dat1;
  logic [4:0]  cnt1;
`ifdef BSG_UPSTREAM_PARITY_EN
  logic [1:0]  par0, par1;
`endif
  int n_chk = 0;
  int n_pass = 0;
  int acc;
  logic [15:0] exp_a [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
  logic [1:0]  exp_p [4] = '{2'b11, 2'b10, 2'b00, 2'b11};
  logic [15:0] exp_b [8] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877,
                             16'h9988, 16'hbbaa, 16'hddcc, 16'hffee};
  always #5 clk = ~clk;
  bsg_upstream_serializer u_dut0 (
    .clk(clk), .rst(rst), .core_valid_in(v0), .core_data_in(d0), .core_ready_out(rdy0),
    .io_token(t0), .io_valid_out(val0), .io_data_out(dat0),
`ifdef BSG_UPSTREAM_PARITY_EN
    .io_parity_out(par0),
`endif
    .credit_cnt_o(cnt0), .credit_err_o(err0)
  );
  bsg_upstream_serializer #(.CREDIT_INIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .core_valid_in(v1), .core_data_in(d1), .core_ready_out(rdy1),
    .io_token(t1), .io_valid_out(val1), .io_data_out(dat1),
`ifdef BSG_UPSTREAM_PARITY_EN
    .io_parity_out(par1),
`endif
    .credit_cnt_o(cnt1), .credit_err_o(err1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; v0 = 1'b0; d0 = '0; t0 = 1'b0; v1 = 1'b0; d1 = '0; t1 = 1'b0;
    step();
    step();
    chk("rst_valid", val0, 0);
    chk("rst_data", dat0, 0);
    chk("rst_cnt", cnt0, 16);
    chk("rst_err", err0, 0);
    chk("rst_cnt1", cnt1, 1);
    rst = 1'b0;
    v1 = 1'b1; d1 = 64'h1122334455667788;
    chk("c1_ready_first", rdy1, 1);
    step();
    d1 = 64'h4433221105040301;
    chk("c1_cnt_zero", cnt1, 0);
    chk("c1_blocked", rdy1, 0);
    repeat (5) step();
    chk("c1_still_blocked", rdy1, 0);
    chk("c1_idle", val1, 0);
    t1 = 1'b1;
    step();
    t1 = 1'b0;
    chk("c1_token_cnt", cnt1, 1);
    chk("c1_ready_after_token", rdy1, 1);
    step();
    v1 = 1'b0;
    chk("c1_beat0_valid", val1, 1);
    chk("c1_beat0_data", dat1, 16'h0301);
    chk("c1_cnt_after", cnt1, 0);
`ifdef BSG_UPSTREAM_PARITY_EN
    chk("c1_parity", par1, 2'b01);
`endif
    v0 = 1'b1; d0 = 64'h0807060504030201;
    chk("a_ready", rdy0, 1);
    step();
    v0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("a_valid", val0, 1);
      chk("a_data", dat0, exp_a[i]);
`ifdef BSG_UPSTREAM_PARITY_EN
      chk("a_parity", par0, exp_p[i]);
`endif
      if (i == 0) chk("a_cnt", cnt0, 15);
      step();
    end
    chk("a_idle_valid", val0, 0);
    chk("a_idle_data", dat0, 0);
    chk("a_idle_ready", rdy0, 1);
    v0 = 1'b1; d0 = 64'h8877665544332211;
    step();
    d0 = 64'hffeeddccbbaa9988;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", val0, 1);
      chk("b2b_data", dat0, exp_b[i]);
      if (i == 0) chk("b2b_ready_mid", rdy0, 0);
      if (i == 3) chk("b2b_ready_last", rdy0, 1);
      step();
      if (i == 3) v0 = 1'b0;
    end
    chk("b2b_idle", val0, 0);
    chk("b2b_cnt", cnt0, 13);
    v0 = 1'b1; d0 = 64'h0123456789abcdef;
    acc = 0;
    for (int k = 0; k < 100 && acc < 8; k++) begin
      if (rdy0) acc++;
      step();
    end
    v0 = 1'b0;
    chk("drain_accepts", acc, 8);
    repeat (4) step();
    chk("drain_idle", val0, 0);
    chk("drain_cnt", cnt0, 5);
    v0 = 1'b1; t0 = 1'b1;
    chk("acc_tok_ready", rdy0, 1);
    step();
    v0 = 1'b0; t0 = 1'b0;
    chk("acc_tok_cnt", cnt0, 5);
    chk("acc_tok_valid", val0, 1);
    t0 = 1'b1;
    repeat (11) step();
    t0 = 1'b0;
    chk("tok_fill_cnt", cnt0, 16);
    chk("tok_fill_err", err0, 0);
    t0 = 1'b1;
    step();
    t0 = 1'b0;
    chk("ovf_cnt", cnt0, 16);
    chk("ovf_err", err0, 1);
    repeat (3) step();
    chk("ovf_sticky", err0, 1);
    v0 = 1'b1; d0 = 64'h8877665544332211;
    step();
    v0 = 1'b0;
    step();
    step();
    chk("mid_beat2", dat0, 16'h6655);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", val0, 0);
    chk("mid_rst_data", dat0, 0);
    chk("mid_rst_cnt", cnt0, 16);
    chk("mid_rst_err", err0, 0);
    step();
    chk("mid_rst_no_beats", val0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bsg_upstream_serializer.md
BSG_UPSTREAM_SERIALIZER -- requirements
Module: bsg_upstream_serializer

Interface
REQ-001 SHALL have parameter CORE_W, default 64: core word width in bits.
REQ-002 SHALL have parameter CH_NUM, default 2: number of off-chip channels.
REQ-003 SHALL have parameter CH_W, default 8: width of each channel in bits.
REQ-004 SHALL have parameter CREDIT_MAX, default 16: credit counter ceiling.
REQ-005 SHALL have parameter CREDIT_INIT, default CREDIT_MAX: credit count after reset.
REQ-006 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 core_valid_in  in  1  core word offered.
REQ-009 core_data_in  in  CORE_W  core word.
REQ-010 core_ready_out  out  1  word accepted this cycle when valid is also high.
REQ-011 io_token  in  1  one-credit return pulse, already synchronous to clk.
REQ-012 io_valid_out  out  1  beat valid on the channels.
REQ-013 io_data_out  out  CH_NUM*CH_W  channel data, channel c in slice [c*CH_W +: CH_W].
REQ-014 credit_cnt_o  out  $clog2(CREDIT_MAX+1)  current credits.
REQ-015 credit_err_o  out  1  sticky credit-overflow flag.

Function
REQ-016 BEATS = CORE_W/(CH_NUM*CH_W); a non-integer result SHALL be an elaboration error.
REQ-017 FSM states: IDLE and SEND; beat counter beat_q spans 0..BEATS-1.
REQ-018 core_ready_out = (credit_cnt != 0) & (state==IDLE | (state==SEND & beat_q==BEATS-1)).
REQ-019 Accept (core_valid_in & core_ready_out) SHALL latch the word, set SEND, set beat_q=0, and consume one credit.
REQ-020 A word accepted in cycle N SHALL drive beat 0 in cycle N+1; beats SHALL run in consecutive cycles with no bubbles.
REQ-021 Beat b, channel c SHALL carry word bits [(b*CH_NUM+c)*CH_W +: CH_W].
REQ-022 An accept on the last beat SHALL drive the next word's beat 0 in the following cycle, giving gapless back-to-back words.
REQ-023 At the last beat with no accept, the FSM SHALL return to IDLE.
REQ-024 io_valid_out SHALL be 1 exactly in SEND; io_data_out SHALL be 0 when io_valid_out is 0.
REQ-025 Accept and io_token in the same cycle SHALL leave the credit count unchanged.
REQ-026 io_token at credit_cnt==CREDIT_MAX with no accept SHALL hold the count and set credit_err_o.
REQ-027 credit_err_o SHALL stay 1 until reset.
REQ-028 Credit arithmetic SHALL never wrap; underflow SHALL be impossible by REQ-018.

Reset
REQ-029 rst SHALL give: state IDLE, beat_q 0, io_valid_out 0, io_data_out 0, credit_cnt CREDIT_INIT, credit_err_o 0, holding register 0.
REQ-030 rst mid-word SHALL abort the word, with no further beats from the next cycle; the consumed credit SHALL not be refunded beyond CREDIT_INIT.

Configuration
REQ-031 With BSG_UPSTREAM_PARITY_EN defined, the block SHALL add output io_parity_out[CH_NUM], giving even parity (XOR of channel bits) per channel, registered alongside the data.
REQ-032 io_parity_out SHALL be 0 when io_valid_out is 0.
REQ-033 Without BSG_UPSTREAM_PARITY_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package bsg_upstream_pkg SHALL hold the FSM state enum and the beats/credit-width helper functions.
REQ-035 One sub-module, bsg_upstream_credit_ctr (credit up/down counter with saturation and error flag), SHALL be instantiated once.

Verification (defaults, BEATS=4)
REQ-036 Accept 0x0807060504030201 at credits 16 -> cycles N+1..N+4 ch0/ch1 = 01/02, 03/04, 05/06, 07/08; credit_cnt 15; IDLE at N+5.
REQ-037 Two words back-to-back -> 8 consecutive valid beats with no gap; credit_cnt 14.
REQ-038 CREDIT_INIT=1 with two words offered -> second word blocked (core_ready_out=0) until an io_token pulse, accepted the cycle after, beat 0 one cycle later.
REQ-039 Accept plus io_token at credit_cnt 5 -> remains 5; io_token alone at 16 -> stays 16 and credit_err_o=1 until rst.
REQ-040 rst asserted during beat 2 -> next cycle io_valid_out=0, io_data_out=0, credit_cnt=CREDIT_INIT.
REQ-041 With BSG_UPSTREAM_PARITY_EN, beat ch0=0x01, ch1=0x03 -> io_parity_out = 2'b01.
